// File: rtl/route_pkg.sv
// Shared types and helpers for the IPv4 route lookup engine.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package route_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } route_state_t;

    localparam int PREFIX_W = 32;
    localparam int LEN_W    = 6;

    localparam logic [LEN_W-1:0] MAX_LEN = 6'd32;

    // Network mask for a prefix length; anything at or above 32 is a host route.
    function automatic logic [PREFIX_W-1:0] prefix_mask(input logic [LEN_W-1:0] len);
        logic [PREFIX_W-1:0] m;
        if (len >= MAX_LEN) begin
            m = '1;
        end else begin
            m = ~({PREFIX_W{1'b1}} >> len);
        end
        return m;
    endfunction

endpackage

// File: rtl/route_entry_match.sv
// Compares one route entry against the looked-up address and the current best.
// Latency: combinational.
// Backpressure: none.
module route_entry_match
    import route_pkg::*;
(
    input  logic [PREFIX_W-1:0] i_dest_ip,
    input  logic                i_valid,
    input  logic [PREFIX_W-1:0] i_prefix,
    input  logic [LEN_W-1:0]    i_len,
    input  logic                i_best_hit,
    input  logic [LEN_W-1:0]    i_best_len,
    output logic                o_take
);

    logic [PREFIX_W-1:0] w_mask;
    logic                w_match;

    // Match on masked prefix; only a strictly longer match displaces the best, so ties keep the lower index.
    always_comb begin
        w_mask  = prefix_mask(i_len);
        w_match = i_valid && ((i_dest_ip & w_mask) == (i_prefix & w_mask));
        o_take  = w_match && (!i_best_hit || (i_len > i_best_len));
    end

endmodule

// File: rtl/ip_route_table.sv
// Longest-prefix IPv4 route lookup, one table entry examined per clock.
// Latency: fixed TABLE_DEPTH+1 cycles from request strobe to one-cycle response strobe.
// Backpressure: none; requests arriving while busy are ignored, config writes are never stalled.
module ip_route_table
    import route_pkg::*;
#(
    parameter  int NUM_INTERFACES   = 3,
    parameter  int RX_INTERFACE_NUM = 0,
    parameter  int TABLE_DEPTH      = 8,
    localparam int PW = (NUM_INTERFACES > 1) ? $clog2(NUM_INTERFACES) : 1,
    localparam int AW = $clog2(TABLE_DEPTH)
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_ft_hdr_valid,
    input  logic [47:0]         i_ft_dest_mac,
    input  logic [47:0]         i_ft_src_mac,
    input  logic [31:0]         i_ft_dest_ip,
    input  logic [31:0]         i_ft_source_ip,
    output logic                o_ft_resp_valid,
    output logic [PW-1:0]       o_ft_resp,
    output logic                o_ft_drop_packet,
    input  logic                i_cfg_wr_en,
    input  logic [AW-1:0]       i_cfg_addr,
    input  logic                i_cfg_valid,
    input  logic [31:0]         i_cfg_prefix,
    input  logic [5:0]          i_cfg_prefix_len,
    input  logic [PW-1:0]       i_cfg_port,
    input  logic                i_cfg_drop,
    output logic                o_busy,
    output logic [15:0]         o_drop_count
);

    localparam logic [AW-1:0] LAST_IDX = AW'(TABLE_DEPTH - 1);
    localparam logic [PW-1:0] RX_PORT  = PW'(RX_INTERFACE_NUM);
    localparam logic [PW:0]   NUM_IF_W = (PW+1)'(NUM_INTERFACES);

    // Route table held in flops so reset can invalidate every entry.
    logic                r_ent_valid  [TABLE_DEPTH];
    logic [PREFIX_W-1:0] r_ent_prefix [TABLE_DEPTH];
    logic [LEN_W-1:0]    r_ent_len    [TABLE_DEPTH];
    logic [PW-1:0]       r_ent_port   [TABLE_DEPTH];
    logic                r_ent_drop   [TABLE_DEPTH];

    route_state_t        r_state;
    route_state_t        w_state_nxt;
    logic [AW-1:0]       r_idx;
    logic [PREFIX_W-1:0] r_dest_ip;
    logic                r_bcast;
    logic                r_best_hit;
    logic [LEN_W-1:0]    r_best_len;
    logic [PW-1:0]       r_best_port;
    logic                r_best_drop;

    logic                r_resp_valid;
    logic [PW-1:0]       r_resp;
    logic                r_drop_pkt;
    logic [15:0]         r_drop_count;

    logic                w_take;
    logic                w_last;
    logic                w_fin_hit;
    logic [PW-1:0]       w_fin_port;
    logic                w_fin_drop;
    logic                w_drop;

    // Source addresses are carried on the header bus but play no part in routing.
    logic w_unused_inputs;
    assign w_unused_inputs = ^{i_ft_src_mac, i_ft_source_ip};

    // Control-plane writes land in the table the cycle after the strobe, in any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                r_ent_valid[i]  <= 1'b0;
                r_ent_prefix[i] <= '0;
                r_ent_len[i]    <= '0;
                r_ent_port[i]   <= '0;
                r_ent_drop[i]   <= 1'b0;
            end
        end else if (i_cfg_wr_en) begin
            r_ent_valid[i_cfg_addr]  <= i_cfg_valid;
            r_ent_prefix[i_cfg_addr] <= i_cfg_prefix;
            r_ent_len[i_cfg_addr]    <= (i_cfg_prefix_len > MAX_LEN) ? MAX_LEN : i_cfg_prefix_len;
            r_ent_port[i_cfg_addr]   <= i_cfg_port;
            r_ent_drop[i_cfg_addr]   <= i_cfg_drop;
        end
    end

    route_entry_match u_match (
        .i_dest_ip  (r_dest_ip),
        .i_valid    (r_ent_valid[r_idx]),
        .i_prefix   (r_ent_prefix[r_idx]),
        .i_len      (r_ent_len[r_idx]),
        .i_best_hit (r_best_hit),
        .i_best_len (r_best_len),
        .o_take     (w_take)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: accept in IDLE, walk every entry once, then a single response cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_ft_hdr_valid) w_state_nxt = ST_SCAN;
            ST_SCAN: if (r_idx == LAST_IDX) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the request in IDLE and track the longest match while scanning.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_dest_ip   <= '0;
            r_bcast     <= 1'b0;
            r_best_hit  <= 1'b0;
            r_best_len  <= '0;
            r_best_port <= '0;
            r_best_drop <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_ft_hdr_valid) begin
                        r_dest_ip  <= i_ft_dest_ip;
                        r_bcast    <= (i_ft_dest_ip == 32'hFFFF_FFFF) ||
                                      (i_ft_dest_mac == 48'hFFFF_FFFF_FFFF);
                        r_best_hit <= 1'b0;
                        r_idx      <= '0;
                    end
                end
                ST_SCAN: begin
                    if (w_take) begin
                        r_best_hit  <= 1'b1;
                        r_best_len  <= r_ent_len[r_idx];
                        r_best_port <= r_ent_port[r_idx];
                        r_best_drop <= r_ent_drop[r_idx];
                    end
                    r_idx <= r_idx + AW'(1);
                end
                default: ;
            endcase
        end
    end

    // Fold the last entry into the verdict so the response can be registered on entry to RESP.
    always_comb begin
        w_last     = (r_state == ST_SCAN) && (r_idx == LAST_IDX);
        w_fin_hit  = r_best_hit | w_take;
        w_fin_port = w_take ? r_ent_port[r_idx] : r_best_port;
        w_fin_drop = w_take ? r_ent_drop[r_idx] : r_best_drop;
        w_drop     = r_bcast || !w_fin_hit || w_fin_drop ||
                     (w_fin_port == RX_PORT) || ({1'b0, w_fin_port} >= NUM_IF_W);
    end

    // Registered response, zero outside the response cycle; saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp       <= '0;
            r_drop_pkt   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_resp_valid <= w_last;
            r_resp       <= (w_last && !w_drop) ? w_fin_port : '0;
            r_drop_pkt   <= w_last && w_drop;
            if (w_last && w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign o_ft_resp_valid  = r_resp_valid;
    assign o_ft_resp        = r_resp;
    assign o_ft_drop_packet = r_drop_pkt;
    assign o_drop_count     = r_drop_count;
    assign o_busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ip_route_table.sv
// Bench for ip_route_table: directed vectors, timing corner cases and randomized lookups.
// Latency: expects every response exactly TABLE_DEPTH+1 cycles after the request.
// Backpressure: none exercised; checks that requests while busy are ignored.
module tb_ip_route_table;

    localparam int NIF   = 3;
    localparam int RXI   = 0;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_ft_hdr_valid;
    logic [47:0] i_ft_dest_mac, i_ft_src_mac;
    logic [31:0] i_ft_dest_ip, i_ft_source_ip;
    logic        o_ft_resp_valid;
    logic [1:0]  o_ft_resp;
    logic        o_ft_drop_packet;
    logic        i_cfg_wr_en;
    logic [2:0]  i_cfg_addr;
    logic        i_cfg_valid;
    logic [31:0] i_cfg_prefix;
    logic [5:0]  i_cfg_prefix_len;
    logic [1:0]  i_cfg_port;
    logic        i_cfg_drop;
    logic        o_busy;
    logic [15:0] o_drop_count;

    always #5 clk = ~clk;

    ip_route_table #(
        .NUM_INTERFACES   (NIF),
        .RX_INTERFACE_NUM (RXI),
        .TABLE_DEPTH      (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_ft_hdr_valid   (i_ft_hdr_valid),
        .i_ft_dest_mac    (i_ft_dest_mac),
        .i_ft_src_mac     (i_ft_src_mac),
        .i_ft_dest_ip     (i_ft_dest_ip),
        .i_ft_source_ip   (i_ft_source_ip),
        .o_ft_resp_valid  (o_ft_resp_valid),
        .o_ft_resp        (o_ft_resp),
        .o_ft_drop_packet (o_ft_drop_packet),
        .i_cfg_wr_en      (i_cfg_wr_en),
        .i_cfg_addr       (i_cfg_addr),
        .i_cfg_valid      (i_cfg_valid),
        .i_cfg_prefix     (i_cfg_prefix),
        .i_cfg_prefix_len (i_cfg_prefix_len),
        .i_cfg_port       (i_cfg_port),
        .i_cfg_drop       (i_cfg_drop),
        .o_busy           (o_busy),
        .o_drop_count     (o_drop_count)
    );

    int n_vec = 0;
    int n_err = 0;
    int lat;

    // Reference table: plain arrays, lengths already clamped to 32.
    logic        m_valid  [DEPTH];
    logic [31:0] m_prefix [DEPTH];
    int          m_len    [DEPTH];
    int          m_port   [DEPTH];
    logic        m_drop   [DEPTH];
    int          m_drop_count;

    typedef struct {
        logic [31:0] ip;
        logic [47:0] mac;
        int          port;
        logic        drop;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i]  = 1'b0;
            m_prefix[i] = '0;
            m_len[i]    = 0;
            m_port[i]   = 0;
            m_drop[i]   = 1'b0;
        end
        m_drop_count = 0;
    endtask

    task automatic cfg_drive(input int addr, input logic v, input logic [31:0] pfx,
                             input int len, input int port, input logic drp);
        i_cfg_wr_en      = 1'b1;
        i_cfg_addr       = 3'(addr);
        i_cfg_valid      = v;
        i_cfg_prefix     = pfx;
        i_cfg_prefix_len = 6'(len);
        i_cfg_port       = 2'(port);
        i_cfg_drop       = drp;
        m_valid[addr]    = v;
        m_prefix[addr]   = pfx;
        m_len[addr]      = (len > 32) ? 32 : len;
        m_port[addr]     = port;
        m_drop[addr]     = drp;
    endtask

    task automatic cfg_write(input int addr, input logic v, input logic [31:0] pfx,
                             input int len, input int port, input logic drp);
        cfg_drive(addr, v, pfx, len, port, drp);
        tick();
        i_cfg_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_clear();
    endtask

    // Longest-prefix match by definition: widest mask wins, first one found wins ties.
    task automatic ref_lookup(input logic [31:0] ip, input logic [47:0] mac,
                              output int port, output logic drop);
        int          best;
        int          blen;
        logic [31:0] mask;
        best = -1;
        blen = -1;
        for (int i = 0; i < DEPTH; i++) begin
            mask = (m_len[i] == 0) ? 32'h0 : (32'hFFFF_FFFF << (32 - m_len[i]));
            if (m_valid[i] && ((ip & mask) == (m_prefix[i] & mask)) && (m_len[i] > blen)) begin
                best = i;
                blen = m_len[i];
            end
        end
        if (best < 0) begin
            drop = 1'b1;
        end else begin
            drop = (ip == 32'hFFFF_FFFF) || (mac == 48'hFFFF_FFFF_FFFF) || m_drop[best] ||
                   (m_port[best] == RXI) || (m_port[best] >= NIF);
        end
        port = drop ? 0 : m_port[best];
    endtask

    task automatic start_lookup(input logic [31:0] ip, input logic [47:0] mac);
        i_ft_dest_ip   = ip;
        i_ft_dest_mac  = mac;
        i_ft_src_mac   = {$urandom, $urandom};
        i_ft_source_ip = $urandom;
        i_ft_hdr_valid = 1'b1;
        tick();
        i_ft_hdr_valid = 1'b0;
        lat = 1;
        chk("busy_in_scan", 32'(o_busy), 1);
    endtask

    task automatic finish_lookup(input string nm, input int exp_port, input logic exp_drop);
        int guard;
        guard = 0;
        while (!o_ft_resp_valid && guard < 40) begin
            tick();
            lat++;
            guard++;
        end
        if (!o_ft_resp_valid) begin
            chk({nm, "_timeout"}, 32'(o_ft_resp_valid), 1);
            return;
        end
        if (exp_drop) m_drop_count++;
        chk({nm, "_latency"}, 32'(lat), DEPTH + 1);
        chk({nm, "_resp"}, 32'(o_ft_resp), 32'(exp_port));
        chk({nm, "_drop"}, 32'(o_ft_drop_packet), 32'(exp_drop));
        chk({nm, "_dropcnt"}, 32'(o_drop_count), 32'(m_drop_count));
        tick();
        chk({nm, "_after_resp"}, {28'd0, o_ft_resp_valid, o_ft_drop_packet, o_ft_resp} | {31'd0, o_busy}, 0);
    endtask

    task automatic run_lookup(input string nm, input logic [31:0] ip, input logic [47:0] mac);
        int   p;
        logic d;
        ref_lookup(ip, mac, p, d);
        start_lookup(ip, mac);
        finish_lookup(nm, p, d);
    endtask

    task automatic expect_quiet(input string nm, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            seen = seen | o_ft_resp_valid;
        end
        chk(nm, 32'(seen), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rip;
        logic [47:0] rmac;
        int          sel;

        rst              = 1'b1;
        i_ft_hdr_valid   = 1'b0;
        i_ft_dest_mac    = '0;
        i_ft_src_mac     = '0;
        i_ft_dest_ip     = '0;
        i_ft_source_ip   = '0;
        i_cfg_wr_en      = 1'b0;
        i_cfg_addr       = '0;
        i_cfg_valid      = 1'b0;
        i_cfg_prefix     = '0;
        i_cfg_prefix_len = '0;
        i_cfg_port       = '0;
        i_cfg_drop       = 1'b0;
        model_clear();
        tick();
        do_reset();

        chk("reset_outputs", {27'd0, o_ft_resp_valid, o_ft_drop_packet, o_ft_resp, o_busy}, 0);
        chk("reset_dropcnt", 32'(o_drop_count), 0);

        // Empty table: everything drops.
        start_lookup(32'h0A00_0001, 48'h0000_1111_2222);
        finish_lookup("empty", 0, 1'b1);

        // Directed table.
        cfg_write(0, 1'b1, 32'h0A00_0000,  8, 1, 1'b0);
        cfg_write(1, 1'b1, 32'h0808_0800, 24, 3, 1'b0);
        cfg_write(2, 1'b1, 32'hC0A8_0000, 16, 1, 1'b1);
        cfg_write(3, 1'b1, 32'h0000_0000,  0, 1, 1'b0);
        cfg_write(4, 1'b1, 32'hAC10_0000, 12, 0, 1'b0);
        cfg_write(5, 1'b1, 32'h0A01_0000, 16, 2, 1'b0);
        cfg_write(6, 1'b1, 32'h0000_0000,  0, 2, 1'b0);
        cfg_write(7, 1'b1, 32'h0909_0909, 40, 2, 1'b0);

        vecs[0]  = '{32'h0A01_0203, 48'h0000_1111_2222, 2, 1'b0};
        vecs[1]  = '{32'h0A09_0909, 48'h0000_1111_2222, 1, 1'b0};
        vecs[2]  = '{32'h0B00_0001, 48'h0000_1111_2222, 1, 1'b0};
        vecs[3]  = '{32'hC0A8_0101, 48'h0000_1111_2222, 0, 1'b1};
        vecs[4]  = '{32'hFFFF_FFFF, 48'h0000_1111_2222, 0, 1'b1};
        vecs[5]  = '{32'h0A01_0203, 48'hFFFF_FFFF_FFFF, 0, 1'b1};
        vecs[6]  = '{32'hAC10_0505, 48'h0000_1111_2222, 0, 1'b1};
        vecs[7]  = '{32'hAC20_0001, 48'h0000_1111_2222, 1, 1'b0};
        vecs[8]  = '{32'h0808_0808, 48'h0000_1111_2222, 0, 1'b1};
        vecs[9]  = '{32'h0909_0909, 48'h0000_1111_2222, 2, 1'b0};
        vecs[10] = '{32'h0909_0908, 48'h0000_1111_2222, 1, 1'b0};

        for (int i = 0; i < 11; i++) begin
            start_lookup(vecs[i].ip, vecs[i].mac);
            finish_lookup($sformatf("vec%0d", i), vecs[i].port, vecs[i].drop);
        end

        // A second request while scanning is ignored; exactly one response follows.
        start_lookup(32'h0A09_0909, 48'h0000_1111_2222);
        tick();
        i_ft_dest_ip   = 32'hC0A8_0101;
        i_ft_hdr_valid = 1'b1;
        tick();
        i_ft_hdr_valid = 1'b0;
        lat += 2;
        finish_lookup("busy_ignore", 1, 1'b0);
        expect_quiet("busy_ignore_no_second", 12);

        // Reset mid-lookup: no response, table emptied, counter cleared.
        start_lookup(32'h0A01_0203, 48'h0000_1111_2222);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        chk("rst_abort_busy", 32'(o_busy), 0);
        chk("rst_abort_dropcnt", 32'(o_drop_count), 0);
        expect_quiet("rst_abort_no_resp", 12);
        start_lookup(32'h0A01_0203, 48'h0000_1111_2222);
        finish_lookup("after_rst", 0, 1'b1);

        // Writes during a scan: index not yet scanned counts, index already scanned does not.
        cfg_write(0, 1'b1, 32'h0A00_0000, 8, 1, 1'b0);
        start_lookup(32'h0A01_0203, 48'h0000_1111_2222);
        tick();
        tick();
        cfg_drive(7, 1'b1, 32'h0A01_0200, 24, 2, 1'b0);
        tick();
        cfg_drive(0, 1'b1, 32'h0A01_0200, 28, 1, 1'b0);
        tick();
        i_cfg_wr_en = 1'b0;
        lat += 4;
        finish_lookup("midwr_now", 2, 1'b0);
        start_lookup(32'h0A01_0203, 48'h0000_1111_2222);
        finish_lookup("midwr_next", 1, 1'b0);

        // Randomized table programming and lookups against the reference model.
        do_reset();
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(2) == 0) begin
                cfg_write($urandom_range(DEPTH - 1), ($urandom_range(3) != 0),
                          {8'h0A, 8'($urandom_range(3)), 16'($urandom)},
                          $urandom_range(40), $urandom_range(3), ($urandom_range(4) == 0));
            end else begin
                sel = $urandom_range(7);
                if (sel <= 4)      rip = {8'h0A, 8'($urandom_range(3)), 16'($urandom)};
                else if (sel == 5) rip = 32'hFFFF_FFFF;
                else               rip = $urandom;
                rmac = ($urandom_range(9) == 0) ? 48'hFFFF_FFFF_FFFF : {16'($urandom), $urandom};
                run_lookup($sformatf("rand%0d", it), rip, rmac);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
